// File: rtl/cntr_mod.sv
// Up/down modulo counter with clamped parallel load, cascade tc and sticky wrap.
// Define CNTR_MOD_SAT_EN to saturate at the range ends instead of wrapping.
module cntr_mod #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  logic             at_max;
  logic             at_min;
  logic             hit;
  logic [WIDTH-1:0] ld_sat;
  logic [WIDTH-1:0] nxt;

  assign at_max = (out == MAX_VAL);
  assign at_min = (out == '0);
  assign hit    = up ? at_max : at_min;
  assign tc     = ce & ((up & at_max) | (~up & at_min));
  assign ld_sat = (ld_val > MAX_VAL) ? MAX_VAL : ld_val;

  // Terminal compare comes first, so the add never needs a carry bit.
  always_comb begin
    nxt = out;
    if (hit) begin
`ifdef CNTR_MOD_SAT_EN
      nxt = out;
`else
      nxt = up ? '0 : MAX_VAL;
`endif
    end else if (up) begin
      nxt = out + 1'b1;
    end else begin
      nxt = out - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (ld) begin
      out  <= ld_sat;
      wrap <= wrap & ~clr_wrap;
    end else if (ce) begin
      out  <= nxt;
      wrap <= hit | (wrap & ~clr_wrap);
    end else begin
      wrap <= wrap & ~clr_wrap;
    end
  end

endmodule

// File: doc/cntr_mod.md
# cntr_mod

Parametrised up/down modulo counter: the next-generation general counter for the design. It adds a configurable width and modulus, direction control, synchronous parallel load, a cascade terminal-count output and a sticky wrap flag. Multi-digit, multi-stage chains are built by feeding one stage's `tc` into the next stage's `ce`. It sits wherever the design needs event counting, timebase division or display-digit counting.

## Interface
- `WIDTH`, default 16: counter width in bits; legal range 2..32.
- `MAX_VAL`, default 2**WIDTH-1: highest count value; counter range is 0..MAX_VAL; must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ce`  in  1: count enable; one step per cycle while high.
- `up`  in  1: direction, 1 = increment, 0 = decrement; sampled only when counting.
- `ld`  in  1: synchronous load strobe.
- `ld_val`  in  WIDTH: load value.
- `clr_wrap`  in  1: clears the sticky `wrap` flag.
- `out`  out  WIDTH: current count, registered.
- `tc`  out  1: terminal count, combinational: `ce & ((up & out==MAX_VAL) | (~up & out==0))`.
- `wrap`  out  1: sticky flag, registered; set when a wrap (or a saturation hit, see Configuration) occurs.

## Operation
- Priority per cycle: `rst` > `ld` > `ce` > hold.
- `rst`=1: `out`←0, `wrap`←0; all other inputs are ignored that cycle.
- `ld`=1: `out`←`ld_val` if `ld_val` ≤ MAX_VAL, else `out`←MAX_VAL (clamp). A load never sets `wrap` and overrides `ce` in the same cycle.
- `ce`=1, `up`=1:
  - `out`<MAX_VAL: `out`←`out`+1.
  - `out`==MAX_VAL: `out`←0 and `wrap`←1.
- `ce`=1, `up`=0:
  - `out`>0: `out`←`out`−1.
  - `out`==0: `out`←MAX_VAL and `wrap`←1.
- Arithmetic is WIDTH bits, and the compare against MAX_VAL is done before the add, so no carry beyond WIDTH bits is ever needed. When MAX_VAL = 2**WIDTH−1, behaviour matches natural binary roll-over.
- `clr_wrap`=1 clears `wrap`. If a wrap event occurs in the same cycle, set wins and `wrap` stays 1.
- `tc` is asserted exactly in the cycle whose clock edge performs the wrap, so a downstream stage with `ce`=`tc` steps on that same edge.
- Direction may change on any cycle with no penalty. Reversal at a terminal value takes effect immediately: at `out`=MAX_VAL with `up`=0, the counter decrements and no `tc` is generated.
- Reset mid-count takes effect on the next edge regardless of `ld`/`ce`.

## Timing
- Reset values: `out`=0, `wrap`=0. `tc` is 0 after reset unless `ce`=1 and `up`=0, because `out`==0.
- `out` latency: 1 cycle from `ce`/`ld` to the updated value.
- `wrap` latency: set on the same edge that wraps `out`.
- `tc` has 0 latency (combinational); the path is one WIDTH-bit compare plus an AND.
- No handshake. `ce` may toggle every cycle; the maximum count rate is one step per clock.

## Configuration
- Macro `CNTR_MOD_SAT_EN`.
- Defined: saturating mode.
  - Incrementing at MAX_VAL holds MAX_VAL; decrementing at 0 holds 0.
  - `wrap` is set on each such blocked step and acts as a saturation flag.
  - `tc` keeps the same definition.
  - Load behaviour is unchanged.
- Undefined (default): modulo wrap as described in Operation.
- The macro selects logic at compile time only; there is no runtime mode port.

## Test plan
- Reset: drive `ld`=1, `ld_val`=5, then `rst`=1 with `ce`=1 → `out`=0, `wrap`=0 after the edge.
- WIDTH=4, MAX_VAL=9, up: ce=1 for 10 cycles from 0 → `out` steps 0..9; `tc`=1 only while `out`=9; `out`=0 and `wrap`=1 on the 10th edge.
- Down wrap: MAX_VAL=9, `out`=0, `up`=0, ce=1 → `tc`=1, next `out`=9, `wrap`=1. Then assert `clr_wrap` alone → `wrap`=0. Then assert `clr_wrap` coincident with a wrap → `wrap` stays 1.
- Load: `ld`=1, `ld_val`=12 with MAX_VAL=9 and `ce`=1 → `out`=9 (clamped), no increment, `wrap` unchanged.
- Cascade: two WIDTH=4, MAX_VAL=9 stages, stage1 `ce`=stage0 `tc`; run 100 steps from 00 → stage1/stage0 read 0/0, with stage1 having wrapped once, and the stage1 `tc` pulse on the 100th step.
- With `CNTR_MOD_SAT_EN`: MAX_VAL=9, up from 8 for 3 cycles → `out`=9,9,9 and `wrap`=1; down from 1 for 2 cycles → `out`=0,0.
